// File: rtl/sync_pkg.sv
// Shared constants and helpers for the multi-channel synchronizer / edge detector.
package sync_pkg;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int k = 0; k < 31; k++) begin
      if ((32'sd1 <<< k) < value) begin
        result = k + 1;
      end
    end
    return result;
  endfunction
endpackage

// File: rtl/sync_chan.sv
// One channel: STAGES-deep synchronizer, optional debounce filter and edge memory.
// With SYNC_STICKY_EN defined, a sticky event flag set by pulse and cleared by ack_i.
module sync_chan
  import sync_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter int   DEBOUNCE  = 0,
  parameter int   EDGE_MODE = EDGE_FALL,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
`ifdef SYNC_STICKY_EN
  input  logic ack_i,
  output logic event_o,
`endif
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic pulse_o
);
  localparam int            CW       = (DEBOUNCE > 0) ? clog2(DEBOUNCE + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (DEBOUNCE > 0) ? CW'(DEBOUNCE - 1) : '0;

  logic [STAGES-1:0] sync_q;
  logic              level_q, level_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              lvl_q;
  logic              s;
  logic              rise, fall;

  assign s = sync_q[STAGES-1];

  // Synchronizer chain, filtered level, debounce count and edge memory.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= {STAGES{RESET_VAL}};
      level_q <= RESET_VAL;
      cnt_q   <= '0;
      lvl_q   <= RESET_VAL;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], d_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      lvl_q   <= level_q;
    end
  end

  // Level only moves after DEBOUNCE consecutive samples disagree with it.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (DEBOUNCE == 0) begin
      level_d = s;
      cnt_d   = '0;
    end else if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign rise    = level_q & ~lvl_q;
  assign fall    = ~level_q & lvl_q;
  assign level_o = level_q;
  assign rise_o  = rise;
  assign fall_o  = fall;

  always_comb begin
    pulse_o = 1'b0;
    case (EDGE_MODE)
      EDGE_RISE: pulse_o = rise;
      EDGE_FALL: pulse_o = fall;
      EDGE_BOTH: pulse_o = rise | fall;
      default:   pulse_o = 1'b0;
    endcase
  end

`ifdef SYNC_STICKY_EN
  logic event_q, event_d;

  // A new pulse takes priority over a coincident acknowledge.
  always_comb begin
    event_d = event_q;
    if (pulse_o) begin
      event_d = 1'b1;
    end else if (ack_i) begin
      event_d = 1'b0;
    end else begin
      event_d = event_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      event_q <= 1'b0;
    end else begin
      event_q <= event_d;
    end
  end

  assign event_o = event_q;
`endif
endmodule

// File: rtl/sync_edge_multi.sv
// WIDTH independent synchronizer / debounce / edge-detect channels.
// Define SYNC_STICKY_EN to add per-channel sticky event flags with ack.
module sync_edge_multi
  import sync_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   STAGES    = 2,
  parameter int   DEBOUNCE  = 0,
  parameter int   EDGE_MODE = 1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i,
`ifdef SYNC_STICKY_EN
  input  logic [WIDTH-1:0] ack,
  output logic [WIDTH-1:0] event_o,
`endif
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] pulse
);
  if (EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_BOTH) begin : g_bad_mode
    $error("sync_edge_multi: EDGE_MODE must be 0, 1 or 2");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sync_edge_multi: WIDTH must be 1..32");
  end
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_edge_multi: STAGES must be 2..4");
  end
  if (DEBOUNCE < 0) begin : g_bad_debounce
    $error("sync_edge_multi: DEBOUNCE must be non-negative");
  end

  for (genvar n = 0; n < WIDTH; n++) begin : g_chan
    sync_chan #(
      .STAGES   (STAGES),
      .DEBOUNCE (DEBOUNCE),
      .EDGE_MODE(EDGE_MODE),
      .RESET_VAL(RESET_VAL)
    ) u_chan (
      .clk_i  (clock),
      .rst_i  (reset),
      .d_i    (i[n]),
`ifdef SYNC_STICKY_EN
      .ack_i  (ack[n]),
      .event_o(event_o[n]),
`endif
      .level_o(level[n]),
      .rise_o (rise[n]),
      .fall_o (fall[n]),
      .pulse_o(pulse[n])
    );
  end
endmodule

// File: tb/tb_sync_edge_multi.sv
// Bench for sync_edge_multi: three configurations against a sample-history reference model.
module tb_sync_edge_multi;
  logic       clock;
  logic       reset;
  logic [7:0] i;
  logic [7:0] level_a, rise_a, fall_a, pulse_a;
  logic [7:0] level_b, rise_b, fall_b, pulse_b;
  logic [3:0] level_c, rise_c, fall_c, pulse_c;
`ifdef SYNC_STICKY_EN
  logic [7:0] ack;
  logic [7:0] event_a, event_b;
  logic [3:0] event_c;
  logic [7:0] em_a, em_b, em_c;
`endif

  int checks, failures, cyc;
  int nr_b[8], nf_b[8], np_b[8], first_b[8], last_b[8];
  int np_c;

  // a: D=0 falling; b: D=3 both edges; c: 3 stages, D=4, rising, reset value 1
  sync_edge_multi #(.WIDTH(8), .STAGES(2), .DEBOUNCE(0), .EDGE_MODE(1), .RESET_VAL(1'b0)) dut_a (
    .clock(clock), .reset(reset), .i(i),
`ifdef SYNC_STICKY_EN
    .ack(ack), .event_o(event_a),
`endif
    .level(level_a), .rise(rise_a), .fall(fall_a), .pulse(pulse_a));
  sync_edge_multi #(.WIDTH(8), .STAGES(2), .DEBOUNCE(3), .EDGE_MODE(2), .RESET_VAL(1'b0)) dut_b (
    .clock(clock), .reset(reset), .i(i),
`ifdef SYNC_STICKY_EN
    .ack(ack), .event_o(event_b),
`endif
    .level(level_b), .rise(rise_b), .fall(fall_b), .pulse(pulse_b));
  sync_edge_multi #(.WIDTH(4), .STAGES(3), .DEBOUNCE(4), .EDGE_MODE(0), .RESET_VAL(1'b1)) dut_c (
    .clock(clock), .reset(reset), .i(i[3:0]),
`ifdef SYNC_STICKY_EN
    .ack(ack[3:0]), .event_o(event_c),
`endif
    .level(level_c), .rise(rise_c), .fall(fall_c), .pulse(pulse_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // h[k] is the input sampled k+1 edges ago; the synchronized value is h[STAGES-1].
  logic [7:0] h_a [0:15];
  logic [7:0] h_b [0:15];
  logic [7:0] h_c [0:15];
  logic [7:0] lm_a, pm_a, lm_b, pm_b, lm_c, pm_c;
  logic [7:0] er_a, ef_a, ep_a, er_b, ef_b, ep_b, er_c, ef_c, ep_c;

  assign er_a = lm_a & ~pm_a;
  assign ef_a = ~lm_a & pm_a;
  assign ep_a = ef_a;
  assign er_b = lm_b & ~pm_b;
  assign ef_b = ~lm_b & pm_b;
  assign ep_b = er_b | ef_b;
  assign er_c = lm_c & ~pm_c;
  assign ef_c = ~lm_c & pm_c;
  assign ep_c = er_c;

  // A channel flips once the last d synchronized samples all disagree with its level.
  function automatic logic [7:0] next_level(input logic [7:0] h [0:15], input int st,
                                            input int d, input logic [7:0] lvl);
    logic [7:0] nl;
    logic       all_diff;
    for (int ch = 0; ch < 8; ch++) begin
      if (d == 0) begin
        nl[ch] = h[st-1][ch];
      end else begin
        all_diff = 1'b1;
        for (int k = 0; k < d; k++) begin
          if (h[st-1+k][ch] == lvl[ch]) all_diff = 1'b0;
        end
        nl[ch] = all_diff ? ~lvl[ch] : lvl[ch];
      end
    end
    return nl;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        h_a[k] <= 8'h00;
        h_b[k] <= 8'h00;
        h_c[k] <= 8'hFF;
      end
      lm_a <= 8'h00; pm_a <= 8'h00;
      lm_b <= 8'h00; pm_b <= 8'h00;
      lm_c <= 8'hFF; pm_c <= 8'hFF;
`ifdef SYNC_STICKY_EN
      em_a <= 8'h00; em_b <= 8'h00; em_c <= 8'h00;
`endif
    end else begin
      h_a[0] <= i;
      h_b[0] <= i;
      h_c[0] <= {4'hF, i[3:0]};
      for (int k = 1; k < 16; k++) begin
        h_a[k] <= h_a[k-1];
        h_b[k] <= h_b[k-1];
        h_c[k] <= h_c[k-1];
      end
      pm_a <= lm_a; lm_a <= next_level(h_a, 2, 0, lm_a);
      pm_b <= lm_b; lm_b <= next_level(h_b, 2, 3, lm_b);
      pm_c <= lm_c; lm_c <= next_level(h_c, 3, 4, lm_c);
`ifdef SYNC_STICKY_EN
      em_a <= ep_a | (em_a & ~ack);
      em_b <= ep_b | (em_b & ~ack);
      em_c <= {4'h0, ep_c[3:0] | (em_c[3:0] & ~ack[3:0])};
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int b = 0; b < 8; b++) begin
      nr_b[b] = 0; nf_b[b] = 0; np_b[b] = 0; first_b[b] = 0; last_b[b] = 0;
    end
    np_c = 0;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      cyc++;
      chk("level_a", 32'(level_a), 32'(lm_a));
      chk("rise_a", 32'(rise_a), 32'(er_a));
      chk("fall_a", 32'(fall_a), 32'(ef_a));
      chk("pulse_a", 32'(pulse_a), 32'(ep_a));
      chk("level_b", 32'(level_b), 32'(lm_b));
      chk("rise_b", 32'(rise_b), 32'(er_b));
      chk("fall_b", 32'(fall_b), 32'(ef_b));
      chk("pulse_b", 32'(pulse_b), 32'(ep_b));
      chk("level_c", 32'(level_c), 32'(lm_c[3:0]));
      chk("rise_c", 32'(rise_c), 32'(er_c[3:0]));
      chk("fall_c", 32'(fall_c), 32'(ef_c[3:0]));
      chk("pulse_c", 32'(pulse_c), 32'(ep_c[3:0]));
`ifdef SYNC_STICKY_EN
      chk("event_a", 32'(event_a), 32'(em_a));
      chk("event_b", 32'(event_b), 32'(em_b));
      chk("event_c", 32'(event_c), 32'(em_c[3:0]));
`endif
      for (int b = 0; b < 8; b++) begin
        if (rise_b[b]) nr_b[b]++;
        if (fall_b[b]) nf_b[b]++;
        if (pulse_b[b]) begin
          np_b[b]++;
          if (np_b[b] == 1) first_b[b] = cyc;
          last_b[b] = cyc;
        end
      end
      np_c += $countones(pulse_c);
    end
  endtask

  initial begin
    int tot;
    logic [31:0] r;
    checks = 0; failures = 0; cyc = 0;
    clr();
    reset = 1'b1;
    i = 8'h00;
`ifdef SYNC_STICKY_EN
    ack = 8'h00;
`endif
    repeat (3) @(negedge clock);
    chk("rst_level_a", 32'(level_a), 32'h00);
    chk("rst_level_b", 32'(level_b), 32'h00);
    chk("rst_level_c", 32'(level_c), 32'hF);
    chk("rst_pulse_all", 32'({pulse_a, pulse_b, pulse_c}), 32'h0);
    reset = 1'b0;
    run(1);
    chk("rel_edges_zero", 32'({rise_a | fall_a, rise_b | fall_b, rise_c | fall_c}), 32'h0);
    run(12);

    // Single falling channel on the undebounced instance
    i = 8'hFF; run(15);
    i = 8'hFE; run(3);
    chk("t1_fall_a", 32'(fall_a), 32'h01);
    chk("t1_pulse_a", 32'(pulse_a), 32'h01);
    run(1);
    chk("t1_fall_a_gone", 32'(fall_a), 32'h00);

    // Short glitch filtered, then a held change passes
    i = 8'h00; run(12);
    clr();
    i = 8'h02; run(2);
    i = 8'h00; run(10);
    chk("t2_glitch_rise", 32'(nr_b[1]), 32'd0);
    chk("t2_glitch_level", 32'(level_b), 32'h00);
    i = 8'h02; run(5);
    chk("t2_rise_b", 32'(rise_b), 32'h02);
    run(1);
    chk("t2_rise_b_gone", 32'(rise_b), 32'h00);
    run(6);
    chk("t2_single_rise", 32'(nr_b[1]), 32'd1);

    // 20-cycle pulse in both-edge mode
    i = 8'h00; run(10);
    clr();
    i = 8'h04; run(20);
    i = 8'h00; run(10);
    chk("t3_pulse_count", 32'(np_b[2]), 32'd2);
    chk("t3_rise_count", 32'(nr_b[2]), 32'd1);
    chk("t3_fall_count", 32'(nf_b[2]), 32'd1);
    chk("t3_spacing", 32'(last_b[2] - first_b[2]), 32'd20);

    // All channels change together
    i = 8'hFF; run(3);
    chk("t5_rise_a", 32'(rise_a), 32'hFF);
    chk("t5_pulse_a_none", 32'(pulse_a), 32'h00);
    run(2);
    chk("t5_pulse_b", 32'(pulse_b), 32'hFF);
    run(2);
    chk("t5_pulse_c", 32'(pulse_c), 32'hF);
    i = 8'h00; run(3);
    chk("t5_pulse_a", 32'(pulse_a), 32'hFF);
    run(10);

    // Toggling every cycle never gets through a debounce of 3 or more
    clr();
    for (int k = 0; k < 20; k++) begin
      i = ~i;
      run(1);
    end
    run(10);
    tot = 0;
    for (int b = 0; b < 8; b++) tot += np_b[b];
    chk("t6_toggle_b", 32'(tot), 32'd0);
    chk("t6_toggle_c", 32'(np_c), 32'd0);

    // Reset in the middle of a debounce count
    i = 8'h0F; run(10);
    i = 8'h00; run(5);
    reset = 1'b1;
    #1;
    chk("t4_level_c_async", 32'(level_c), 32'hF);
    chk("t4_level_b_async", 32'(level_b), 32'h00);
    chk("t4_pulse_c_rst", 32'(pulse_c | rise_c | fall_c), 32'h0);
    run(2);
    reset = 1'b0;
    run(1);
    chk("t4_rel_pulse_c", 32'(pulse_c | rise_c | fall_c), 32'h0);
    run(6);
    chk("t4_fresh_fall_c", 32'(fall_c), 32'hF);
    run(5);

    // Random sparse toggling
    for (int k = 0; k < 400; k++) begin
      r = $urandom & $urandom & $urandom;
      i = i ^ r[7:0];
`ifdef SYNC_STICKY_EN
      r = $urandom & $urandom;
      ack = r[7:0];
`endif
      run(1);
    end

`ifdef SYNC_STICKY_EN
    // Sticky flag set, ack clear, and set winning over ack
    i = 8'hFF; ack = 8'hFF; run(10);
    ack = 8'h00;
    i = 8'hF7; run(3);
    chk("t6s_pulse_a3", 32'(pulse_a), 32'h08);
    chk("t6s_event_pre", 32'(event_a[3]), 32'd0);
    run(1);
    chk("t6s_event_set", 32'(event_a[3]), 32'd1);
    run(2);
    ack = 8'h08; run(1);
    chk("t6s_event_clr", 32'(event_a[3]), 32'd0);
    ack = 8'h00;
    i = 8'hFF; run(5);
    i = 8'hF7; run(3);
    ack = 8'h08; run(1);
    chk("t6s_set_wins", 32'(event_a[3]), 32'd1);
    ack = 8'h00; run(3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
